interleave_buf: RTL and testbench
=================================

# interleave_buf

Ping-pong frame interleaver in front of the second component decoder of the turbo decoder. Accepts one frame of extrinsic values (from the first decoder) plus systematic samples, four symbols per beat in natural order. Replays the frame four symbols per beat in row/column-interleaved order, to drive the second decoder's `z1_1..z1_4` and `x_i1..x_i4` inputs. Two frame banks allow one frame to be written while the previous frame is read.

## Interface
- `ROWS`, 8, interleaver rows; multiple of 4
- `COLS`, 8, interleaver columns; multiple of 4
- `ZW`, 30, extrinsic width
- `XW`, 16, systematic width
- `clk` in 1, single clock; all logic on rising edge
- `rst` in 1, reset, asynchronous, active-low
- `in_valid` in 1, input beat valid
- `in_ready` out 1, input beat accepted when `in_valid && in_ready`
- `z_in1..z_in4` in ZW each, extrinsic; lane j carries symbol 4k+j of beat k
- `x_in1..x_in4` in XW each, systematic, same lane ordering
- `out_valid` out 1, output beat valid
- `out_ready` in 1, output beat consumed when `out_valid && out_ready`
- `out_sof` out 1, high on the first beat of each output frame
- `z_out1..z_out4` out ZW each, interleaved extrinsic
- `x_out1..x_out4` out XW each, interleaved systematic

## Operation
- N = ROWS*COLS symbols per frame; B = N/4 beats per frame, on both input and output.
- **Write side:**
  - Input symbol n = 4k+j goes to address n of bank `wr_sel`.
  - `wr_cnt` runs 0..B-1.
  - On the accepted beat with `wr_cnt == B-1`: set `full[wr_sel]`, toggle `wr_sel`, clear `wr_cnt`.
- `in_ready = !full[wr_sel]`.
- **Read side:**
  - Output beat m, lane j: p = 4m+j.
  - Read address = (p mod ROWS)*COLS + (p div ROWS), taken from bank `rd_sel`.
  - `rd_cnt` runs 0..B-1.
- `out_valid = full[rd_sel]`; `out_sof = out_valid && rd_cnt == 0`.
- On a consumed beat with `rd_cnt == B-1`: clear `full[rd_sel]`, toggle `rd_sel`, clear `rd_cnt`.
- When `out_valid` is low, all `z_out`/`x_out` are driven 0. Data is never X on an idle bus.
- **Per-bank states:** EMPTY → (last write beat) → FULL → (last read beat) → EMPTY.
- The write bank and read bank are never the same bank while both are active. Setting one bank's flag and clearing the other's in the same cycle is legal and must both take effect.
- Data and addresses pass through unmodified. There is no arithmetic on samples.
- Frames never overlap within a bank. A third frame stalls (`in_ready` = 0) until a bank drains.

## Timing
- **Reset values:**
  - `wr_sel`, `rd_sel`, `wr_cnt`, `rd_cnt`, `full[1:0]` all 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_sof` = 0, data outputs 0.
  - Storage is not cleared.
- **Latency:**
  - `out_valid` rises the cycle after the last input beat of a frame is accepted.
  - Output data is combinational from registered storage and the counters.
- **Throughput:** one beat per cycle on each side. The input can accept continuously for two frames with no output consumption, then stalls.
- **Handshake rules:**
  - Output data and `out_sof` stay stable while `out_valid && !out_ready`.
  - Dropping `in_valid` mid-frame holds `wr_cnt`. The frame resumes at the next beat.
- **Reset mid-frame:** a partial frame is discarded, both banks become EMPTY, and the next input beat is treated as symbol 0.
- A write to bank X and a read from bank Y in the same cycle do not interact.

## Structure
- Shared package `turbo_pkg` holds:
  - `ZW`, `XW`, `ROWS`, `COLS` defaults
  - lane count 4
  - a function returning the interleave address for index p. The future deinterleaver on the `w2` return path reuses it.
- Sub-module `frame_bank`:
  - one bank of N × (ZW+XW) registers
  - one 4-wide write port at beat address k
  - four independent read addresses
  - instantiated twice
- The top level contains only the counters, the select and flag registers, the address generation and the output mux.

## Test plan
- **Single frame, natural data (ROWS = COLS = 8):** symbol n has z = n and x = n+100. Required output:
  - beat 0 = z 0, 8, 16, 24 with `out_sof` = 1
  - beat 1 = z 32, 40, 48, 56
  - beat 2 = z 1, 9, 17, 25
  - beat 15 = z 39, 47, 55, 63 and x 139, 147, 155, 163
  - `out_valid` is high exactly one cycle after input beat 15 is accepted.
- **Back-to-back three frames, `out_ready` = 0:**
  - `in_ready` drops after beat 31 is accepted.
  - Frame 3 stalls.
  - Raising `out_ready` re-asserts `in_ready` the cycle after output beat 15 is consumed.
- **Simultaneous boundary:** last write beat of frame B coincides with last read beat of frame A. Both flags update; the next cycle shows frame B beat 0 with `out_sof` = 1.
- **Backpressure:** random `out_ready`. Data is held stable while stalled; a scoreboard matches the full permutation over 20 frames; `in_valid` gaps do not shift symbol indices.
- **Reset mid-frame:** assert `rst` low after input beat 7. Required response:
  - outputs return to reset values asynchronously
  - a fresh 16-beat frame then comes out correctly permuted, with no residue from the aborted frame.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared turbo-decoder constants and the row/column interleave address map.
// The deinterleaver on the w2 return path is expected to reuse ilv_addr.
package turbo_pkg;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam int DEF_ZW   = 30;
  localparam int DEF_XW   = 16;
  localparam int LANES    = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_t;

  // Output position p walks down a column: row = p mod rows, col = p div rows.
  function automatic int ilv_addr(input int p, input int rows, input int cols);
    return (p % rows) * cols + p / rows;
  endfunction
endpackage

// File: rtl/frame_bank.sv
// One frame of extrinsic+systematic storage: 4-wide beat write port,
// four independent combinational read ports. Storage is never reset.
module frame_bank
  import turbo_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 46,
  localparam int AW = $clog2(N),
  localparam int BW = $clog2(N / LANES)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [BW-1:0]               wbeat,
  input  logic [LANES-1:0][W-1:0]     wdata,
  input  logic [LANES-1:0][AW-1:0]    raddr,
  output logic [LANES-1:0][W-1:0]     rdata
);
  logic [W-1:0] mem [N];

  always_ff @(posedge clk)
    if (we)
      for (int j = 0; j < LANES; j++) mem[{wbeat, 2'(j)}] <= wdata[j];

  for (genvar j = 0; j < LANES; j++) begin : g_rd
    assign rdata[j] = mem[raddr[j]];
  end
endmodule

// File: rtl/interleave_buf.sv
// Ping-pong row/column interleaver: natural-order frame in, interleaved frame
// out, four symbols per beat, two banks so write and read overlap.
module interleave_buf
  import turbo_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int ZW   = DEF_ZW,
  parameter int XW   = DEF_XW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] z_in1,
  input  logic [ZW-1:0] z_in2,
  input  logic [ZW-1:0] z_in3,
  input  logic [ZW-1:0] z_in4,
  input  logic [XW-1:0] x_in1,
  input  logic [XW-1:0] x_in2,
  input  logic [XW-1:0] x_in3,
  input  logic [XW-1:0] x_in4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic [ZW-1:0] z_out1,
  output logic [ZW-1:0] z_out2,
  output logic [ZW-1:0] z_out3,
  output logic [ZW-1:0] z_out4,
  output logic [XW-1:0] x_out1,
  output logic [XW-1:0] x_out2,
  output logic [XW-1:0] x_out3,
  output logic [XW-1:0] x_out4
);
  localparam int N  = ROWS * COLS;
  localparam int B  = N / LANES;
  localparam int AW = $clog2(N);
  localparam int BW = $clog2(B);
  localparam int W  = ZW + XW;

  logic          wr_sel, rd_sel;
  logic [BW-1:0] wr_cnt, rd_cnt;
  bank_st_t      st [2];
  bank_st_t      st_nxt [2];
  logic          wr_fire, rd_fire, wr_last, rd_last;

  logic [LANES-1:0][W-1:0]  wdata;
  logic [LANES-1:0][AW-1:0] raddr;
  logic [1:0][LANES-1:0][W-1:0] bank_rd;
  logic [LANES-1:0][W-1:0]  rd_word;

  assign in_ready  = (st[wr_sel] == EMPTY);
  assign out_valid = (st[rd_sel] == FULL);
  assign out_sof   = out_valid && (rd_cnt == '0);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_last   = wr_fire && (wr_cnt == BW'(B - 1));
  assign rd_last   = rd_fire && (rd_cnt == BW'(B - 1));

  // Each bank evaluated independently so a fill and a drain in one cycle both land.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_nxt[b] = st[b];
      case (st[b])
        EMPTY:   if (wr_last && wr_sel == 1'(b)) st_nxt[b] = FULL;
        FULL:    if (rd_last && rd_sel == 1'(b)) st_nxt[b] = EMPTY;
        default: st_nxt[b] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      st[0]  <= EMPTY;
      st[1]  <= EMPTY;
    end else begin
      st[0] <= st_nxt[0];
      st[1] <= st_nxt[1];
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (rd_fire) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        if (rd_last) rd_sel <= ~rd_sel;
      end
    end
  end

  assign wdata = {{z_in4, x_in4}, {z_in3, x_in3}, {z_in2, x_in2}, {z_in1, x_in1}};

  for (genvar j = 0; j < LANES; j++) begin : g_addr
    assign raddr[j] = AW'(ilv_addr(int'(rd_cnt) * LANES + j, ROWS, COLS));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.N(N), .W(W)) u_bank (
      .clk   (clk),
      .we    (wr_fire && wr_sel == 1'(b)),
      .wbeat (wr_cnt),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (bank_rd[b])
    );
  end

  // Idle bus is forced to zero so stale storage never shows downstream.
  assign rd_word = out_valid ? bank_rd[rd_sel] : '0;

  assign z_out1 = rd_word[0][W-1:XW];
  assign z_out2 = rd_word[1][W-1:XW];
  assign z_out3 = rd_word[2][W-1:XW];
  assign z_out4 = rd_word[3][W-1:XW];
  assign x_out1 = rd_word[0][XW-1:0];
  assign x_out2 = rd_word[1][XW-1:0];
  assign x_out3 = rd_word[2][XW-1:0];
  assign x_out4 = rd_word[3][XW-1:0];
endmodule

// File: tb/tb_interleave_buf.sv
// Directed + randomized bench for interleave_buf with an expected-beat queue.
module tb_interleave_buf;
  localparam int ROWS = 8, COLS = 8, ZW = 30, XW = 16, B = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_sof;
  logic [ZW-1:0] z_in1 = '0, z_in2 = '0, z_in3 = '0, z_in4 = '0;
  logic [XW-1:0] x_in1 = '0, x_in2 = '0, x_in3 = '0, x_in4 = '0;
  logic [ZW-1:0] z_out1, z_out2, z_out3, z_out4;
  logic [XW-1:0] x_out1, x_out2, x_out3, x_out4;

  interleave_buf #(.ROWS(ROWS), .COLS(COLS), .ZW(ZW), .XW(XW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z_in1(z_in1), .z_in2(z_in2), .z_in3(z_in3), .z_in4(z_in4),
    .x_in1(x_in1), .x_in2(x_in2), .x_in3(x_in3), .x_in4(x_in4),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .z_out1(z_out1), .z_out2(z_out2), .z_out3(z_out3), .z_out4(z_out4),
    .x_out1(x_out1), .x_out2(x_out2), .x_out3(x_out3), .x_out4(x_out4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 sof;
    logic [3:0][ZW-1:0]   z;
    logic [3:0][XW-1:0]   x;
  } beat_t;

  beat_t sb[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  bit prod_done = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t obs_beat();
    beat_t o;
    o.sof = out_sof;
    o.z   = {z_out4, z_out3, z_out2, z_out1};
    o.x   = {x_out4, x_out3, x_out2, x_out1};
    return o;
  endfunction

  function automatic logic [ZW-1:0] zv(input int f, input int n);
    return ZW'(f * 1000 + n);
  endfunction
  function automatic logic [XW-1:0] xv(input int f, input int n);
    return XW'(f * 1000 + n + 100);
  endfunction

  // Output position p reads natural symbol at row (p mod ROWS), column (p div ROWS).
  task automatic push_frame(input int f);
    for (int m = 0; m < B; m++) begin
      beat_t e;
      e.sof = (m == 0);
      for (int j = 0; j < 4; j++) begin
        int p, r, c;
        p = 4 * m + j;
        r = p % ROWS;
        c = p / ROWS;
        e.z[j] = zv(f, r * COLS + c);
        e.x[j] = xv(f, r * COLS + c);
      end
      sb.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_beats(input int f, input int k0, input int k1, input int gap_pct);
    for (int k = k0; k <= k1; k++) begin
      int t;
      logic acc;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        tick(1);
      end
      in_valid = 1'b1;
      z_in1 = zv(f, 4*k);   z_in2 = zv(f, 4*k+1);
      z_in3 = zv(f, 4*k+2); z_in4 = zv(f, 4*k+3);
      x_in1 = xv(f, 4*k);   x_in2 = xv(f, 4*k+1);
      x_in3 = xv(f, 4*k+2); x_in4 = xv(f, 4*k+3);
      t = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
        t++;
        if (t > 3000) begin
          chk("in_accept_timeout", 256'(t), 256'(0));
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin tick(1); t++; end
    chk("drain_empty", 256'(sb.size()), 256'(0));
  endtask

  // Every cycle: a valid beat must equal the queue head (covers stall stability);
  // an idle bus must be all zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        chk("sb_nonempty", 256'(sb.size() != 0), 256'(out_valid));
        if (sb.size() != 0) begin
          chk("sb_beat", 256'(obs_beat()), 256'(sb[0]));
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_bus", 256'(obs_beat()), 256'(0));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_sof", 256'(out_sof), 256'(0));
    chk("rst_data", 256'(obs_beat()), 256'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // single frame, natural data
    push_frame(0);
    drive_beats(0, 0, 14, 0);
    chk("t1_ov_before_last", 256'(out_valid), 256'(0));
    drive_beats(0, 15, 15, 0);
    chk("t1_ov_after_last", 256'(out_valid), 256'(1));
    chk("t1_b0_z", 256'({z_out4, z_out3, z_out2, z_out1}), 256'({30'd24, 30'd16, 30'd8, 30'd0}));
    chk("t1_b0_sof", 256'(out_sof), 256'(1));
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk("t1_b1_z", 256'({z_out4, z_out3, z_out2, z_out1}), 256'({30'd56, 30'd48, 30'd40, 30'd32}));
    chk("t1_b1_sof", 256'(out_sof), 256'(0));
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk("t1_b2_z", 256'({z_out4, z_out3, z_out2, z_out1}), 256'({30'd25, 30'd17, 30'd9, 30'd1}));
    out_ready = 1'b1; tick(13); out_ready = 1'b0;
    chk("t1_b15_z", 256'({z_out4, z_out3, z_out2, z_out1}), 256'({30'd63, 30'd55, 30'd47, 30'd39}));
    chk("t1_b15_x", 256'({x_out4, x_out3, x_out2, x_out1}), 256'({16'd163, 16'd155, 16'd147, 16'd139}));
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk("t1_done_ov", 256'(out_valid), 256'(0));
    chk("t1_sb_empty", 256'(sb.size()), 256'(0));

    // three frames back to back, no consumption
    push_frame(1); drive_beats(1, 0, 15, 0);
    push_frame(2); drive_beats(2, 0, 15, 0);
    chk("t2_in_ready_low", 256'(in_ready), 256'(0));
    chk("t2_out_valid", 256'(out_valid), 256'(1));
    push_frame(3);
    fork
      drive_beats(3, 0, 15, 0);
      begin
        tick(4);
        chk("t2_stall", 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        tick(15);
        chk("t2_ready_before_last", 256'(in_ready), 256'(0));
        tick(1);
        chk("t2_ready_after_last", 256'(in_ready), 256'(1));
      end
    join
    drain();
    out_ready = 1'b0;

    // last write of one frame on the same edge as last read of the previous
    push_frame(4); drive_beats(4, 0, 15, 0);
    out_ready = 1'b1;
    push_frame(5); drive_beats(5, 0, 15, 0);
    chk("t3_out_valid", 256'(out_valid), 256'(1));
    chk("t3_sof", 256'(out_sof), 256'(1));
    chk("t3_z1", 256'(z_out1), 256'(zv(5, 0)));
    chk("t3_in_ready", 256'(in_ready), 256'(1));
    drain();
    out_ready = 1'b0;

    // random backpressure and input gaps over 20 frames
    fork
      begin
        for (int f = 6; f < 26; f++) begin
          push_frame(f);
          drive_beats(f, 0, 15, 30);
        end
        prod_done = 1'b1;
      end
      begin
        int t;
        t = 0;
        while (!(prod_done && sb.size() == 0) && t < 20000) begin
          out_ready = 1'($urandom_range(1));
          tick(1);
          t++;
        end
      end
    join
    out_ready = 1'b0;
    chk("t4_drained", 256'(sb.size()), 256'(0));

    // reset in the middle of a frame while another frame is pending
    push_frame(30); drive_beats(30, 0, 15, 0);
    push_frame(31); drive_beats(31, 0, 7, 0);
    chk("t5_pre_ov", 256'(out_valid), 256'(1));
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_in_ready", 256'(in_ready), 256'(1));
    chk("t5_rst_out_valid", 256'(out_valid), 256'(0));
    chk("t5_rst_out_sof", 256'(out_sof), 256'(0));
    chk("t5_rst_data", 256'(obs_beat()), 256'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_frame(32); drive_beats(32, 0, 15, 0);
    drain();
    out_ready = 1'b0;
    tick(2);
    chk("t5_final_idle", 256'(out_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
